// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller for the 5-stage MIPS core.
// Decodes the D/E/M instructions to find data hazards that forwarding cannot
// cover, tracks the shared mult/div unit with a busy countdown, and drives the
// IF/ID enable, PC enable and ID/EX bubble clear. It also counts stalled cycles.
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_D,
   input  logic [31:0] IR_E,
   input  logic [31:0] IR_M,
   output logic        IF_ID_en,
   output logic        PC_en,
   output logic        ID_EX_clr,
   output logic        md_start,
   output logic        md_busy,
   output logic [31:0] stall_cnt
);

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type function codes
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1a;
   localparam logic [5:0] FN_DIVU  = 6'h1b;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2a;

   // Source-operand usage of the D-stage instruction: which of rs/rt are
   // read and how many cycles remain before each value is actually needed.
   typedef struct packed {
      logic       rs_used;
      logic [1:0] rs_tuse;
      logic       rt_used;
      logic [1:0] rt_tuse;
   } use_t;

   // Destination register; $0 doubles as "no destination".
   function automatic logic [4:0] dest_of(input logic [31:0] ir);
      logic [4:0] d;
      d = 5'd0;
      case (ir[31:26])
         OP_RTYPE: begin
            case (ir[5:0])
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL,
               FN_MFHI, FN_MFLO, FN_JALR: d = ir[15:11];
               default:                   d = 5'd0;
            endcase
         end
         OP_ORI, OP_LUI, OP_ADDIU, OP_LW: d = ir[20:16];
         OP_JAL:                          d = 5'd31;
         default:                         d = 5'd0;
      endcase
      return d;
   endfunction

   // Cycles until the result exists when the instruction sits in EX.
   function automatic logic [1:0] tnew_e_of(input logic [31:0] ir);
      logic [1:0] t;
      t = 2'd0;
      case (ir[31:26])
         OP_RTYPE: begin
            case (ir[5:0])
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL,
               FN_MFHI, FN_MFLO: t = 2'd1;
               default:          t = 2'd0;
            endcase
         end
         OP_ORI, OP_LUI, OP_ADDIU: t = 2'd1;
         OP_LW:                    t = 2'd2;
         default:                  t = 2'd0;
      endcase
      return t;
   endfunction

   // Cycles until the result exists when the instruction sits in MEM.
   function automatic logic [1:0] tnew_m_of(input logic [31:0] ir);
      logic [1:0] t;
      t = 2'd0;
      if (ir[31:26] == OP_LW) begin
         t = 2'd1;
      end else begin
         t = 2'd0;
      end
      return t;
   endfunction

   // Which sources the D-stage instruction reads and by when.
   function automatic use_t use_of(input logic [31:0] ir);
      use_t u;
      u = '{rs_used: 1'b0, rs_tuse: 2'd0, rt_used: 1'b0, rt_tuse: 2'd0};
      case (ir[31:26])
         OP_RTYPE: begin
            case (ir[5:0])
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT:
                  u = '{rs_used: 1'b1, rs_tuse: 2'd1, rt_used: 1'b1, rt_tuse: 2'd1};
               FN_SLL:
                  u = '{rs_used: 1'b0, rs_tuse: 2'd0, rt_used: 1'b1, rt_tuse: 2'd1};
               FN_JR, FN_JALR:
                  u = '{rs_used: 1'b1, rs_tuse: 2'd0, rt_used: 1'b0, rt_tuse: 2'd0};
               FN_MTHI, FN_MTLO:
                  u = '{rs_used: 1'b1, rs_tuse: 2'd1, rt_used: 1'b0, rt_tuse: 2'd0};
               default:
                  u = '{rs_used: 1'b0, rs_tuse: 2'd0, rt_used: 1'b0, rt_tuse: 2'd0};
            endcase
         end
         OP_BEQ:
            u = '{rs_used: 1'b1, rs_tuse: 2'd0, rt_used: 1'b1, rt_tuse: 2'd0};
         OP_ORI, OP_ADDIU, OP_LW:
            u = '{rs_used: 1'b1, rs_tuse: 2'd1, rt_used: 1'b0, rt_tuse: 2'd0};
         OP_SW:
            u = '{rs_used: 1'b1, rs_tuse: 2'd1, rt_used: 1'b1, rt_tuse: 2'd2};
         default:
            u = '{rs_used: 1'b0, rs_tuse: 2'd0, rt_used: 1'b0, rt_tuse: 2'd0};
      endcase
      return u;
   endfunction

   // mult/multu/div/divu
   function automatic logic is_md_op(input logic [31:0] ir);
      logic r;
      r = 1'b0;
      if (ir[31:26] == OP_RTYPE) begin
         case (ir[5:0])
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: r = 1'b1;
            default:                            r = 1'b0;
         endcase
      end else begin
         r = 1'b0;
      end
      return r;
   endfunction

   // Any instruction touching the mult/div unit or HI/LO.
   function automatic logic is_hilo_op(input logic [31:0] ir);
      logic r;
      r = 1'b0;
      if (ir[31:26] == OP_RTYPE) begin
         case (ir[5:0])
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO: r = 1'b1;
            default:                            r = 1'b0;
         endcase
      end else begin
         r = 1'b0;
      end
      return r;
   endfunction

   // One source against the EX and MEM producers.
   function automatic logic src_hazard(input logic       used,
                                       input logic [1:0] tuse,
                                       input logic [4:0] src,
                                       input logic [4:0] dst_e,
                                       input logic [1:0] tnew_e,
                                       input logic [4:0] dst_m,
                                       input logic [1:0] tnew_m);
      logic hit_e;
      logic hit_m;
      hit_e = (dst_e != 5'd0) && (src == dst_e) && (tuse < tnew_e);
      hit_m = (dst_m != 5'd0) && (src == dst_m) && (tuse < tnew_m);
      return used && (hit_e || hit_m);
   endfunction

   logic [CNT_W-1:0] cnt_r;
   logic [31:0]      stall_cnt_r;
   logic             data_stall_s;
   logic             md_start_s;
   logic             md_busy_s;
   logic             md_stall_s;
   logic             stall_s;
   logic             e_is_div_s;
   use_t             use_d_s;
   logic [4:0]       dst_e_s;
   logic [4:0]       dst_m_s;
   logic [1:0]       tnew_e_s;
   logic [1:0]       tnew_m_s;

   // Hazard detection and mult/div scheduling decisions, zero-cycle from IRs.
   always_comb begin
      use_d_s      = use_of(IR_D);
      dst_e_s      = dest_of(IR_E);
      dst_m_s      = dest_of(IR_M);
      tnew_e_s     = tnew_e_of(IR_E);
      tnew_m_s     = tnew_m_of(IR_M);
      data_stall_s = src_hazard(use_d_s.rs_used, use_d_s.rs_tuse, IR_D[25:21],
                                dst_e_s, tnew_e_s, dst_m_s, tnew_m_s)
                   | src_hazard(use_d_s.rt_used, use_d_s.rt_tuse, IR_D[20:16],
                                dst_e_s, tnew_e_s, dst_m_s, tnew_m_s);
      md_start_s   = is_md_op(IR_E);
      e_is_div_s   = (IR_E[5:0] == FN_DIV) || (IR_E[5:0] == FN_DIVU);
      md_busy_s    = md_start_s | (cnt_r != {CNT_W{1'b0}});
      md_stall_s   = md_busy_s & is_hilo_op(IR_D);
      stall_s      = data_stall_s | md_stall_s;
   end

   // Mult/div busy countdown; a start always reloads, reset abandons it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (md_start_s) begin
         cnt_r <= e_is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (cnt_r != {CNT_W{1'b0}}) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Stalled-cycle performance counter, free-running with natural wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_r <= 32'd0;
      end else if (stall_s) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign IF_ID_en  = ~stall_s;
   assign PC_en     = ~stall_s;
   assign ID_EX_clr = stall_s;
   assign md_start  = md_start_s;
   assign md_busy   = md_busy_s;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: expected outputs are queued as each
// step is driven and popped/compared once the combinational outputs settle.
module tb_hazard_stall_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] IR_D;
   logic [31:0] IR_E;
   logic [31:0] IR_M;
   logic        IF_ID_en;
   logic        PC_en;
   logic        ID_EX_clr;
   logic        md_start;
   logic        md_busy;
   logic [31:0] stall_cnt;

   hazard_stall_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .IR_D      (IR_D),
      .IR_E      (IR_E),
      .IR_M      (IR_M),
      .IF_ID_en  (IF_ID_en),
      .PC_en     (PC_en),
      .ID_EX_clr (ID_EX_clr),
      .md_start  (md_start),
      .md_busy   (md_busy),
      .stall_cnt (stall_cnt)
   );

   typedef struct {
      logic        stall;
      logic        start;
      logic        busy;
      logic [31:0] cnt;
      logic        chk_cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_cnt = 32'd0;

   localparam logic [31:0] NOP = 32'h0000_0000;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
      logic [31:0] w;
      w = {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
      return w;
   endfunction

   function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt);
      logic [31:0] w;
      w = {op, 5'(rs), 5'(rt), 16'h0000};
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, expv, $time);
      end
   endtask

   // One directed step: drive at negedge, queue expectation, check after settle.
   task automatic step(input string name, input logic rst,
                       input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic x_stall, input logic x_start, input logic x_busy,
                       input logic chk_cnt, input logic preload);
      exp_t x;
      @(negedge clk);
      reset = rst;
      IR_D  = d;
      IR_E  = e;
      IR_M  = m;
      if (preload) begin
         model_cnt = 32'hFFFF_FFFF;
         force dut.stall_cnt_r = 32'hFFFF_FFFF;
         #1;
         release dut.stall_cnt_r;
      end
      x.stall = x_stall; x.start = x_start; x.busy = x_busy;
      x.cnt = model_cnt; x.chk_cnt = chk_cnt;
      exp_q.push_back(x);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s scoreboard empty", name);
      end else begin
         x = exp_q.pop_front();
         check({name, ".IF_ID_en"},  {31'd0, IF_ID_en},  {31'd0, ~x.stall});
         check({name, ".PC_en"},     {31'd0, PC_en},     {31'd0, ~x.stall});
         check({name, ".ID_EX_clr"}, {31'd0, ID_EX_clr}, {31'd0, x.stall});
         check({name, ".md_start"},  {31'd0, md_start},  {31'd0, x.start});
         check({name, ".md_busy"},   {31'd0, md_busy},   {31'd0, x.busy});
         if (x.chk_cnt) begin
            check({name, ".stall_cnt"}, stall_cnt, x.cnt);
         end
      end
      // Counter effect of the coming rising edge.
      if (rst) begin
         model_cnt = 32'd0;
      end else if (x_stall) begin
         model_cnt = model_cnt + 32'd1;
      end
   endtask

   initial begin
      logic [31:0] lw8, addu988, addu312, beq3, sw3, lw0, addu200, sw5, addu655;
      logic [31:0] lw4, sw5_4, lw7, beq7, jal_i, jr31, mult12, mflo4, div12, mfhi4;
      lw8     = i_ins(6'h23, 0, 8);
      addu988 = r_ins(8, 8, 9, 6'h21);
      addu312 = r_ins(1, 2, 3, 6'h21);
      beq3    = i_ins(6'h04, 3, 0);
      sw3     = i_ins(6'h2b, 0, 3);
      lw0     = i_ins(6'h23, 1, 0);
      addu200 = r_ins(0, 0, 2, 6'h21);
      sw5     = i_ins(6'h2b, 1, 5);
      addu655 = r_ins(5, 5, 6, 6'h21);
      lw4     = i_ins(6'h23, 0, 4);
      sw5_4   = i_ins(6'h2b, 4, 5);
      lw7     = i_ins(6'h23, 0, 7);
      beq7    = i_ins(6'h04, 7, 0);
      jal_i   = {6'h03, 26'h0000100};
      jr31    = r_ins(31, 0, 0, 6'h08);
      mult12  = r_ins(1, 2, 0, 6'h18);
      mflo4   = r_ins(0, 0, 4, 6'h12);
      div12   = r_ins(1, 2, 0, 6'h1a);
      mfhi4   = r_ins(0, 0, 4, 6'h10);

      reset = 1'b1; IR_D = NOP; IR_E = NOP; IR_M = NOP;

      //    name          rst   D        E        M      stall start busy chk pre
      step("reset",       1'b1, NOP,     NOP,     NOP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step("idle",        1'b0, NOP,     NOP,     NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("loaduse",     1'b0, addu988, lw8,     NOP,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("loaduse_m",   1'b0, addu988, NOP,     lw8,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("beq_e",       1'b0, beq3,    addu312, NOP,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("beq_m",       1'b0, beq3,    NOP,     addu312, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("sw_rt",       1'b0, sw3,     addu312, NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("dest0",       1'b0, addu200, lw0,     NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("nodest",      1'b0, addu655, sw5,     NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("sw_rs_lw",    1'b0, sw5_4,   lw4,     NOP,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("beq_lw_m",    1'b0, beq7,    NOP,     lw7,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step("jr_jal",      1'b0, jr31,    jal_i,   NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      // Multiply: start cycle plus five busy cycles hold mflo for six cycles.
      step("mult_start",  1'b0, mflo4,   mult12,  NOP,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step($sformatf("mult_busy%0d", i), 1'b0, mflo4, NOP, NOP, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      step("mult_done",   1'b0, mflo4,   NOP,     NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      // Divide, then reset part-way through the countdown.
      step("div_start",   1'b0, NOP,     div12,   NOP,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step($sformatf("div_busy%0d", i), 1'b0, NOP, NOP, NOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end
      step("div_reset",   1'b1, mfhi4,   NOP,     NOP,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step("after_reset", 1'b0, mfhi4,   NOP,     NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      // Counter wrap from all-ones.
      step("wrap_stall",  1'b0, addu988, lw8,     NOP,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step("wrap_zero",   1'b0, NOP,     NOP,     NOP,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
